// File: rtl/lcd_value_display.sv
// lcd_value_display: HD44780 power-up init plus CLEAR/DISPLAY of a signed 16-bit value as sign and 5 digits.
module lcd_value_display #(
  parameter int PWRUP_CYCLES = 750000,
  parameter int E_PULSE      = 25,
  parameter int CMD_WAIT     = 2000,
  parameter int CLR_WAIT     = 82000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [1:0]  op,
  input  logic [15:0] value,
  output logic        busy,
  output logic        done,
  output logic        lcd_done,
  output logic [7:0]  lcd_data_bus,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_e
);
  typedef enum logic [2:0] {PWRUP, INIT, IDLE, CONVERT, SEND, DONE} state_t;
  localparam int MAX_W   = CLR_WAIT > CMD_WAIT ? CLR_WAIT : CMD_WAIT;
  localparam int MAX_B   = E_PULSE + MAX_W > 16 ? E_PULSE + MAX_W : 16;
  localparam int MAX_CNT = PWRUP_CYCLES > MAX_B ? PWRUP_CYCLES : MAX_B;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] PW_LAST   = CW'(PWRUP_CYCLES - 1);
  localparam logic [CW-1:0] E_LAST    = CW'(E_PULSE);
  localparam logic [CW-1:0] CMD_LAST  = CW'(E_PULSE + CMD_WAIT);
  localparam logic [CW-1:0] CLR_LAST  = CW'(E_PULSE + CLR_WAIT);
  localparam logic [CW-1:0] CONV_LAST = CW'(16);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [1:0]    op_q, op_d;
  logic          sign_q, sign_d;
  logic [16:0]   mag_q, mag_d;
  logic [19:0]   bcd_q, bcd_d, bcd_adj;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d;
  logic          e_q, e_d;
  logic          lcd_done_q, lcd_done_d;
  logic [2:0]    nidx;
  logic [3:0]    dig;
  logic [7:0]    init_byte, char_byte;
  logic          byte_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= PWRUP;
      cnt_q      <= '0;
      idx_q      <= '0;
      op_q       <= '0;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      bcd_q      <= '0;
      data_q     <= '0;
      rs_q       <= 1'b0;
      e_q        <= 1'b0;
      lcd_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      op_q       <= op_d;
      sign_q     <= sign_d;
      mag_q      <= mag_d;
      bcd_q      <= bcd_d;
      data_q     <= data_d;
      rs_q       <= rs_d;
      e_q        <= e_d;
      lcd_done_q <= lcd_done_d;
    end
  end

  for (genvar i = 0; i < 5; i++) begin : g_adj
    assign bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] > 4'd4 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
  end

  // nidx selects the byte that follows the current one within INIT or SEND
  assign nidx      = idx_q + 3'd1;
  assign byte_end  = cnt_q == ((!rs_q && data_q == 8'h01) ? CLR_LAST : CMD_LAST);
  assign init_byte = nidx == 3'd1 ? 8'h0C : nidx == 3'd2 ? 8'h01 : 8'h06;
  assign dig       = nidx == 3'd2 ? bcd_q[19:16] : nidx == 3'd3 ? bcd_q[15:12] :
                     nidx == 3'd4 ? bcd_q[11:8]  : nidx == 3'd5 ? bcd_q[7:4] : bcd_q[3:0];
  assign char_byte = nidx == 3'd1 ? (sign_q ? 8'h2D : 8'h2B) : {4'h3, dig};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    idx_d      = idx_q;
    op_d       = op_q;
    sign_d     = sign_q;
    mag_d      = mag_q;
    bcd_d      = bcd_q;
    data_d     = data_q;
    rs_d       = rs_q;
    lcd_done_d = lcd_done_q;
    case (state_q)
      PWRUP: if (cnt_q == PW_LAST) begin
        state_d = INIT;
        cnt_d   = '0;
        idx_d   = '0;
        data_d  = 8'h38;
        rs_d    = 1'b0;
      end
      INIT: if (byte_end) begin
        cnt_d = '0;
        if (idx_q == 3'd3) begin
          state_d    = IDLE;
          lcd_done_d = 1'b1;
        end else begin
          idx_d  = nidx;
          data_d = init_byte;
        end
      end
      IDLE: begin
        cnt_d = '0;
        if (req) begin
          op_d    = op;
          sign_d  = value[15];
          mag_d   = value[15] ? 17'd0 - {1'b1, value} : {1'b0, value};
          bcd_d   = '0;
          idx_d   = '0;
          state_d = op == 2'd3 ? DONE : op == 2'd2 ? SEND : CONVERT;
          if (op == 2'd2) begin
            data_d = 8'h01;
            rs_d   = 1'b0;
          end
        end
      end
      CONVERT: begin
        bcd_d = 20'({bcd_adj, mag_q[16]});
        mag_d = {mag_q[15:0], 1'b0};
        if (cnt_q == CONV_LAST) begin
          state_d = SEND;
          cnt_d   = '0;
          idx_d   = '0;
          data_d  = op_q[0] ? 8'hC0 : 8'h80;
          rs_d    = 1'b0;
        end
      end
      SEND: if (byte_end) begin
        cnt_d = '0;
        if (op_q[1] || idx_q == 3'd6) begin
          state_d = DONE;
        end else begin
          idx_d  = nidx;
          data_d = char_byte;
          rs_d   = 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    // E is registered from the next counter value so it is glitch-free at the pin
    e_d = (state_d == INIT || state_d == SEND) && cnt_d != '0 && cnt_d <= E_LAST;
  end

  always_comb begin
    busy = !(state_q == IDLE || state_q == DONE);
    done = state_q == DONE;
  end

  assign lcd_done     = lcd_done_q;
  assign lcd_data_bus = data_q;
  assign lcd_rs       = rs_q;
  assign lcd_rw       = 1'b0;
  assign lcd_e        = e_q;
endmodule

// File: doc/lcd_value_display.md
Name: lcd_value_display

Overview:
- Downstream consumer of the control unit's LCD outputs for the HD44780-compatible 16x2 character LCD on the board.
- Runs the power-up init sequence and reports completion on lcd_done, which gates the control unit's Init -> Fetch transition.
- Afterwards it accepts CLEAR and DISPLAY requests and prints a signed 16-bit register value as sign plus 5 decimal digits.
- Owns all LCD bus timing (E pulse width, per-command wait) so the control unit only issues single-cycle requests.

Parameters:
- PWRUP_CYCLES, 750000: wait after reset before the first command (15 ms at 50 MHz).
- E_PULSE, 25: cycles lcd_e is held high per byte.
- CMD_WAIT, 2000: cycles waited after E falls for every byte except 0x01 (40 us).
- CLR_WAIT, 82000: cycles waited after E falls for the 0x01 command (1.64 ms).

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- req, in, 1: request strobe; sampled only while busy=0 and lcd_done=1.
- op, in, 2: 00 = DISPLAY on line 1, 01 = DISPLAY on line 2, 10 = CLEAR, 11 = reserved (accepted, no bus activity).
- value, in, 16: signed two's-complement value, latched on acceptance.
- busy, out, 1: high from acceptance until done.
- done, out, 1: one-cycle pulse when a request completes.
- lcd_done, out, 1: init sequence complete; stays high until reset.
- lcd_data_bus, out, 8: LCD data.
- lcd_rs, out, 1: 0 = command, 1 = character.
- lcd_rw, out, 1: tied 0.
- lcd_e, out, 1: LCD enable strobe.

Behaviour:
- Reset values: busy=1, done=0, lcd_done=0, lcd_data_bus=0x00, lcd_rs=0, lcd_rw=0, lcd_e=0; state PWRUP. Reset mid-transfer aborts immediately, with no partial E pulse completion.
- States: PWRUP, INIT, IDLE, CONVERT, SEND, DONE.
- PWRUP: counts PWRUP_CYCLES, then enters INIT.
- INIT: sends 0x38, 0x0C, 0x01, 0x06 (rs=0) in order via the byte-write engine. After the last wait: lcd_done=1, busy=0, enter IDLE.
- Byte-write engine:
  - Data and rs are set 1 cycle before E rises.
  - E stays high for E_PULSE cycles.
  - After E falls, data and rs are held through the wait: CLR_WAIT if the command byte is 0x01, else CMD_WAIT.
  - The next byte starts the cycle after the wait ends.
- IDLE: req=1 accepts the request. In the same edge, op and value are latched and busy=1 on the next cycle. req while busy or before lcd_done is ignored; nothing is queued.
- CLEAR: sends 0x01, then enters DONE.
- DISPLAY:
  - CONVERT computes the magnitude as 17-bit |value|, so -32768 gives 32768.
  - Conversion is double-dabble, one bit per cycle, exactly 17 cycles, producing 5 BCD digits.
  - SEND then writes the address command (0x80 for line 1, 0xC0 for line 2) followed by 6 characters (rs=1): sign ('+' 0x2B for value>=0, '-' 0x2D otherwise), then 5 digits as 0x30+d, most significant first, with leading zeros kept.
- DONE: done=1 for one cycle, busy=0 in the same cycle, return to IDLE. A req in the DONE cycle is ignored.
- Reserved op: goes straight to DONE on the cycle after acceptance.
- Deterministic latency for DISPLAY with E_PULSE=P and CMD_WAIT=W: 1 + 17 + 7*(1+P+W) cycles from acceptance to the done pulse.
- lcd_rw is always 0.

Test Plan:
- Sim parameters: PWRUP_CYCLES=10, E_PULSE=2, CMD_WAIT=4, CLR_WAIT=8. Release reset -> exactly 4 E pulses carrying 0x38, 0x0C, 0x01, 0x06 with rs=0. Gap after 0x01 is 8 cycles, others 4. lcd_done rises after the last wait.
- DISPLAY line 1, value=+123 -> bytes 0x80 (rs=0), then 0x2B 0x30 0x30 0x31 0x32 0x33 (rs=1). done pulses once at acceptance+1+17+7*7 cycles.
- DISPLAY line 2, value=-32768 (0x8000) -> 0xC0, then "-32768" (0x2D 0x33 0x32 0x37 0x36 0x38). Also value=-1 -> "-00001", value=0 -> "+00000".
- CLEAR while idle -> single 0x01 byte followed by an 8-cycle wait, then done. A req held high throughout busy -> no second transaction until after done and one idle cycle.
- req asserted before lcd_done, and during DISPLAY with value changing mid-transfer -> the pre-init req is ignored, and the printed digits match the value latched at acceptance.
- Assert reset during the 3rd character's E pulse -> lcd_e=0, busy=1, lcd_done=0 immediately. After release, the full init sequence repeats from PWRUP.
